// File: rtl/axi4_a23_refill_pkg.sv
// Shared types and AXI constants for the A23 dual-port line-fill arbiter.
package axi4_a23_refill_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_4B     = 3'b010;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef logic owner_t;

endpackage

// File: rtl/axi4_a23_rr_arb2.sv
// Two-input round-robin select: on a tie the port that did not win last time is chosen.
module axi4_a23_rr_arb2
  import axi4_a23_refill_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  input  owner_t     upd_owner,
  output logic       any,
  output owner_t     sel
);

  owner_t last_owner;

  // Reset to port 1 so port 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner <= 1'b1;
    end else if (update) begin
      last_owner <= upd_owner;
    end
  end

  assign any = |req;
  assign sel = (&req) ? ~last_owner : (req[1] & ~req[0]);

endmodule

// File: rtl/axi4_a23_refill_arb.sv
// Shares one AXI4 read port between I-cache (port 0) and D-cache (port 1) line fills, one burst at a time.
// Optional data-phase watchdog enabled by defining AXI4_A23_REFILL_ARB_TIMEOUT_EN.
module axi4_a23_refill_arb
  import axi4_a23_refill_pkg::*;
#(
  parameter int WORDS_PER_LINE = 4,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int ID_BASE        = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_req0_valid,
  input  logic [31:0]             i_req0_addr,
  output logic                    o_req0_grant,
  output logic                    o_req0_data_valid,
  input  logic                    i_req1_valid,
  input  logic [31:0]             i_req1_addr,
  output logic                    o_req1_grant,
  output logic                    o_req1_data_valid,
  output logic [31:0]             o_rd_data,
  output logic                    o_rd_last,
  output logic                    o_err,
  output logic                    o_arvalid,
  input  logic                    i_arready,
  output logic [31:0]             o_araddr,
  output logic [7:0]              o_arlen,
  output logic [2:0]              o_arsize,
  output logic [1:0]              o_arburst,
  output logic [AXI_ID_WIDTH-1:0] o_arid,
  input  logic                    i_rvalid,
  output logic                    o_rready,
  input  logic [31:0]             i_rdata,
  input  logic [1:0]              i_rresp,
  input  logic                    i_rlast
);

  localparam int BW  = $clog2(WORDS_PER_LINE);
  localparam int OFF = $clog2(WORDS_PER_LINE * 4);
  localparam logic [BW-1:0] LAST_BEAT  = BW'(WORDS_PER_LINE - 1);
  localparam logic [31:0]   ALIGN_MASK = ~((32'd1 << OFF) - 32'd1);

  state_t        state;
  owner_t        owner;
  logic [BW-1:0] beat_cnt;
  logic          any_req;
  owner_t        sel;
  logic          ar_hs;
  logic          beat;
  logic          is_last;
  logic          tmo_hit;

  assign ar_hs   = (state == ADDR) && i_arready;
  assign beat    = (state == DATA) && i_rvalid;
  assign is_last = (beat_cnt == LAST_BEAT);

  axi4_a23_rr_arb2 u_arb (
    .clk       (i_clk),
    .rst       (i_rst),
    .req       ({i_req1_valid, i_req0_valid}),
    .update    (ar_hs),
    .upd_owner (owner),
    .any       (any_req),
    .sel       (sel)
  );

`ifdef AXI4_A23_REFILL_ARB_TIMEOUT_EN
  logic [31:0] tmo_cnt;

  // Counts cycles without progress; any handshake or beat restarts it.
  always_ff @(posedge i_clk) begin
    if (i_rst || state == IDLE || ar_hs || beat) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 32'd1;
    end
  end

  assign tmo_hit = (state != IDLE) && !ar_hs && !beat && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES != 0);
  assign tmo_hit    = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      beat_cnt  <= '0;
      o_arvalid <= 1'b0;
      o_araddr  <= '0;
      o_arlen   <= '0;
      o_arid    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner     <= sel;
            o_araddr  <= (sel ? i_req1_addr : i_req0_addr) & ALIGN_MASK;
            o_arlen   <= 8'(WORDS_PER_LINE - 1);
            o_arid    <= AXI_ID_WIDTH'(ID_BASE) + AXI_ID_WIDTH'(sel);
            o_arvalid <= 1'b1;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (tmo_hit) begin
            o_arvalid <= 1'b0;
            state     <= IDLE;
          end else if (i_arready) begin
            o_arvalid <= 1'b0;
            beat_cnt  <= '0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (tmo_hit) begin
            beat_cnt <= '0;
            state    <= IDLE;
          end else if (i_rvalid) begin
            // Burst length is fixed by the line size, not by i_rlast.
            if (is_last) begin
              beat_cnt <= '0;
              state    <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_arsize          = SIZE_4B;
  assign o_arburst         = BURST_INCR;
  assign o_rready          = (state == DATA);
  assign o_req0_grant      = ar_hs && (owner == 1'b0);
  assign o_req1_grant      = ar_hs && (owner == 1'b1);
  assign o_req0_data_valid = (beat || tmo_hit) && (owner == 1'b0);
  assign o_req1_data_valid = (beat || tmo_hit) && (owner == 1'b1);
  assign o_rd_data         = ((state == DATA) && !tmo_hit) ? i_rdata : 32'd0;
  assign o_rd_last         = (beat && is_last) || tmo_hit;
  assign o_err             = tmo_hit ||
                             (beat && ((|(i_rresp & RESP_SLVERR)) || (i_rlast != is_last)));

endmodule

// File: tb/tb_axi4_a23_refill_arb.sv
// Directed bench for axi4_a23_refill_arb; expectations queue up at stimulus time and a negedge monitor checks them.
module tb_axi4_a23_refill_arb;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_req0_valid = 1'b0, i_req1_valid = 1'b0;
  logic [31:0] i_req0_addr = '0, i_req1_addr = '0;
  logic        o_req0_grant, o_req1_grant, o_req0_data_valid, o_req1_data_valid;
  logic [31:0] o_rd_data, o_araddr;
  logic        o_rd_last, o_err, o_arvalid, o_rready;
  logic        i_arready = 1'b0;
  logic [7:0]  o_arlen;
  logic [2:0]  o_arsize;
  logic [1:0]  o_arburst;
  logic [3:0]  o_arid;
  logic        i_rvalid = 1'b0, i_rlast = 1'b0;
  logic [31:0] i_rdata = '0;
  logic [1:0]  i_rresp = '0;

  axi4_a23_refill_arb #(
    .WORDS_PER_LINE(4), .AXI_ID_WIDTH(4), .ID_BASE(0), .TIMEOUT_CYCLES(16)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req0_valid(i_req0_valid), .i_req0_addr(i_req0_addr),
    .o_req0_grant(o_req0_grant), .o_req0_data_valid(o_req0_data_valid),
    .i_req1_valid(i_req1_valid), .i_req1_addr(i_req1_addr),
    .o_req1_grant(o_req1_grant), .o_req1_data_valid(o_req1_data_valid),
    .o_rd_data(o_rd_data), .o_rd_last(o_rd_last), .o_err(o_err),
    .o_arvalid(o_arvalid), .i_arready(i_arready), .o_araddr(o_araddr),
    .o_arlen(o_arlen), .o_arsize(o_arsize), .o_arburst(o_arburst), .o_arid(o_arid),
    .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rdata(i_rdata),
    .i_rresp(i_rresp), .i_rlast(i_rlast)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { int port; logic [31:0] addr; logic [3:0] id; } ar_exp_t;
  typedef struct { int port; logic [31:0] data; logic last; logic err; } beat_exp_t;

  ar_exp_t   ar_q[$];
  beat_exp_t beat_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents an AR handshake or a beat.
  ar_exp_t     a;
  beat_exp_t   b;
  logic        prev_stall = 1'b0;
  logic [43:0] prev_ar;
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_arvalid && i_arready) begin
        if (ar_q.size() == 0) chk("ar_unexpected", 32'd1, 32'd0);
        else begin
          a = ar_q.pop_front();
          chk("araddr", o_araddr, a.addr);
          chk("arlen", {24'd0, o_arlen}, 32'd3);
          chk("arid", {28'd0, o_arid}, {28'd0, a.id});
          chk("grant", {30'd0, o_req1_grant, o_req0_grant}, (a.port == 1) ? 32'd2 : 32'd1);
        end
      end else if (o_req0_grant || o_req1_grant) begin
        chk("grant_spurious", {30'd0, o_req1_grant, o_req0_grant}, 32'd0);
      end
      if (prev_stall && o_arvalid)
        chk("ar_stable", {o_araddr, o_arlen, o_arid}, prev_ar);
      prev_stall <= o_arvalid && !i_arready;
      prev_ar    <= {o_araddr, o_arlen, o_arid};
      if (o_req0_data_valid || o_req1_data_valid) begin
        if (beat_q.size() == 0) chk("beat_unexpected", 32'd1, 32'd0);
        else begin
          b = beat_q.pop_front();
          chk("beat_port", {30'd0, o_req1_data_valid, o_req0_data_valid}, (b.port == 1) ? 32'd2 : 32'd1);
          chk("rd_data", o_rd_data, b.data);
          chk("rd_last", {31'd0, o_rd_last}, {31'd0, b.last});
          chk("err", {31'd0, o_err}, {31'd0, b.err});
        end
      end else if (o_err || o_rd_last) begin
        chk("err_last_spurious", {30'd0, o_err, o_rd_last}, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic ar_phase(input int port, input logic [31:0] exp_addr, input int ar_delay,
                          input bit rer, input logic [31:0] rer_addr);
    int waited = 0;
    ar_q.push_back('{port: port, addr: exp_addr, id: 4'(port)});
    while (!o_arvalid && waited < 50) begin
      tick();
      waited++;
    end
    if (!o_arvalid) begin
      chk("arvalid_timeout", 32'd0, 32'd1);
      return;
    end
    for (int i = 0; i < ar_delay; i++) begin
      chk("arvalid_hold", {31'd0, o_arvalid}, 32'd1);
      tick();
    end
    i_arready = 1'b1;
    tick();
    i_arready = 1'b0;
    if (port == 0) i_req0_valid = 1'b0; else i_req1_valid = 1'b0;
    if (rer) begin
      tick();
      if (port == 0) begin i_req0_valid = 1'b1; i_req0_addr = rer_addr; end
      else begin i_req1_valid = 1'b1; i_req1_addr = rer_addr; end
    end
  endtask

  task automatic r_phase(input int port, input int nslots, input logic [15:0] vpat,
                         input logic [31:0] dbase, input logic [3:0] resp_m,
                         input logic [3:0] last_m, input logic [3:0] err_m);
    int idx = 0;
    for (int s = 0; s < nslots; s++) begin
      if (vpat[s]) begin
        i_rvalid = 1'b1;
        i_rdata  = dbase + 32'(idx);
        i_rresp  = resp_m[idx] ? 2'b10 : 2'b00;
        i_rlast  = last_m[idx];
        beat_q.push_back('{port: port, data: dbase + 32'(idx), last: (idx == 3), err: err_m[idx]});
        idx++;
      end else begin
        i_rvalid = 1'b0;
        i_rdata  = 32'hDEAD_BEEF;
        i_rlast  = 1'b0;
        i_rresp  = 2'b00;
      end
      tick();
    end
    i_rvalid = 1'b0;
    i_rlast  = 1'b0;
    i_rresp  = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    chk("rst_arvalid", {31'd0, o_arvalid}, 32'd0);
    chk("rst_araddr", o_araddr, 32'd0);
    chk("rst_arlen", {24'd0, o_arlen}, 32'd0);
    chk("rst_arid", {28'd0, o_arid}, 32'd0);
    chk("rst_arsize", {29'd0, o_arsize}, 32'd2);
    chk("rst_arburst", {30'd0, o_arburst}, 32'd1);
    chk("rst_rready", {31'd0, o_rready}, 32'd0);
    chk("rst_flags", {26'd0, o_req0_grant, o_req1_grant, o_req0_data_valid,
                      o_req1_data_valid, o_rd_last, o_err}, 32'd0);
    chk("rst_rd_data", o_rd_data, 32'd0);

    // Tie right after reset, requesters re-raise after each grant: order 0,1,0,1.
    i_req0_valid = 1'b1; i_req0_addr = 32'h0000_2008;
    i_req1_valid = 1'b1; i_req1_addr = 32'h0000_3FFC;
    ar_phase(0, 32'h0000_2000, 0, 1'b1, 32'h0000_4010);
    r_phase(0, 4, 16'hF, 32'h10, 4'b0000, 4'b1000, 4'b0000);
    ar_phase(1, 32'h0000_3FF0, 0, 1'b1, 32'h0000_5004);
    r_phase(1, 4, 16'hF, 32'h20, 4'b0000, 4'b1000, 4'b0000);
    ar_phase(0, 32'h0000_4010, 0, 1'b0, 32'h0);
    r_phase(0, 4, 16'hF, 32'h30, 4'b0000, 4'b1000, 4'b0000);
    ar_phase(1, 32'h0000_5000, 0, 1'b0, 32'h0);
    r_phase(1, 4, 16'hF, 32'h40, 4'b0000, 4'b1000, 4'b0000);

    // Port 0 alone, beats 0xA0..0xA3.
    i_req0_valid = 1'b1; i_req0_addr = 32'h0000_1234;
    ar_phase(0, 32'h0000_1230, 0, 1'b0, 32'h0);
    r_phase(0, 4, 16'hF, 32'hA0, 4'b0000, 4'b1000, 4'b0000);

    // AR stalled five cycles.
    i_req1_valid = 1'b1; i_req1_addr = 32'h0000_00FF;
    ar_phase(1, 32'h0000_00F0, 5, 1'b0, 32'h0);
    r_phase(1, 4, 16'hF, 32'hB0, 4'b0000, 4'b1000, 4'b0000);

    // Gapped R channel 1,0,0,1,1,0,1.
    i_req0_valid = 1'b1; i_req0_addr = 32'h8888_8888;
    ar_phase(0, 32'h8888_8880, 0, 1'b0, 32'h0);
    r_phase(0, 7, 16'h0059, 32'hC0, 4'b0000, 4'b1000, 4'b0000);

    // SLVERR on beat 2, early rlast on beat 1.
    i_req1_valid = 1'b1; i_req1_addr = 32'h0000_0010;
    ar_phase(1, 32'h0000_0010, 0, 1'b0, 32'h0);
    r_phase(1, 4, 16'hF, 32'hD0, 4'b0100, 4'b1010, 4'b0110);

    // Reset after two beats, then a fresh port 1 fill.
    i_req0_valid = 1'b1; i_req0_addr = 32'h0000_0100;
    ar_phase(0, 32'h0000_0100, 0, 1'b0, 32'h0);
    r_phase(0, 2, 16'h3, 32'hE0, 4'b0000, 4'b0000, 4'b0000);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("midrst_arvalid", {31'd0, o_arvalid}, 32'd0);
    chk("midrst_rready", {31'd0, o_rready}, 32'd0);
    chk("midrst_araddr", o_araddr, 32'd0);
    chk("midrst_flags", {30'd0, o_req0_data_valid, o_rd_last}, 32'd0);
    i_req1_valid = 1'b1; i_req1_addr = 32'h0000_0204;
    ar_phase(1, 32'h0000_0200, 0, 1'b0, 32'h0);
    r_phase(1, 4, 16'hF, 32'hF0, 4'b0000, 4'b1000, 4'b0000);

`ifdef AXI4_A23_REFILL_ARB_TIMEOUT_EN
    // Silent R channel: forced last with error, then back to IDLE.
    i_req0_valid = 1'b1; i_req0_addr = 32'h0000_0040;
    ar_phase(0, 32'h0000_0040, 0, 1'b0, 32'h0);
    beat_q.push_back('{port: 0, data: 32'd0, last: 1'b1, err: 1'b1});
    repeat (20) tick();
    chk("tmo_rready", {31'd0, o_rready}, 32'd0);
`endif

    repeat (4) tick();
    chk("ar_q_drained", 32'(ar_q.size()), 32'd0);
    chk("beat_q_drained", 32'(beat_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
